add_pc4: RTL and testbench

- Registered program-counter incrementer for the RISC-V fetch stage.
- Samples the current PC and produces the next sequential address, PC + 4, one clock later.
- A synchronous active-high reset forces the next-address output to zero.
- The result feeds the PC-select mux and the link-address path (JAL/JALR).

---
 rtl/add_pc4.sv | 49 ++++
 tb/tb_add_pc4.sv | 127 ++++++++++++
 2 files changed

// File: rtl/add_pc4.sv
// Registered PC + INC incrementer for the fetch stage.
// The carry-out and a since-reset valid flag are registered alongside the sum.
module add_pc4 #(
  parameter int WIDTH = 10,
  parameter int INC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] siguiente,
  output logic             valid,
  output logic             wrap
);

  localparam logic [WIDTH:0] INC_EXT = (WIDTH + 1)'(INC);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] siguiente_r;
  logic             valid_r;
  logic             wrap_r;

  // One extra bit of sum width carries the wrap indication.
  always_comb begin
    sum_s = {1'b0, PC} + INC_EXT;
  end

  // Output registers; reset has priority, and a stall holds every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      siguiente_r <= {WIDTH{1'b0}};
      valid_r     <= 1'b0;
      wrap_r      <= 1'b0;
    end else if (en) begin
      siguiente_r <= sum_s[WIDTH-1:0];
      valid_r     <= 1'b1;
      wrap_r      <= sum_s[WIDTH];
    end else begin
      siguiente_r <= siguiente_r;
      valid_r     <= valid_r;
      wrap_r      <= wrap_r;
    end
  end

  assign siguiente = siguiente_r;
  assign valid     = valid_r;
  assign wrap      = wrap_r;

endmodule

// File: tb/tb_add_pc4.sv
// Self-checking bench for add_pc4: directed boundary cases, then random
// stimulus against an arithmetic reference model.
module tb_add_pc4;

  localparam int WIDTH = 10;
  localparam int INC   = 4;
  localparam int MODV  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [WIDTH-1:0] pc  = '0;
  logic [WIDTH-1:0] siguiente;
  logic             valid;
  logic             wrap;

  int check_cnt_s = 0;
  int bad_cnt_s   = 0;

  int exp_sig_s  = 0;
  int exp_val_s  = 0;
  int exp_wrap_s = 0;

  add_pc4 #(.WIDTH(WIDTH), .INC(INC)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .PC        (pc),
    .siguiente (siguiente),
    .valid     (valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    check_cnt_s++;
    if (got != exp) begin
      bad_cnt_s++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs, clock once, advance the model, then compare all outputs.
  task automatic step(input logic r, input logic e, input int p, input string tag);
    int sum;
    rst = r;
    en  = e;
    pc  = WIDTH'(p);
    @(posedge clk);
    if (r) begin
      exp_sig_s  = 0;
      exp_val_s  = 0;
      exp_wrap_s = 0;
    end else if (e) begin
      sum        = (p % MODV) + INC;
      exp_sig_s  = sum % MODV;
      exp_wrap_s = (sum >= MODV) ? 1 : 0;
      exp_val_s  = 1;
    end
    #1;
    check_eq({tag, ".siguiente"}, int'(siguiente), exp_sig_s);
    check_eq({tag, ".valid"},     int'(valid),     exp_val_s);
    check_eq({tag, ".wrap"},      int'(wrap),      exp_wrap_s);
  endtask

  initial begin
    // Reset with live PC and enable
    step(1'b1, 1'b1, 123, "reset0");
    step(1'b1, 1'b1, 123, "reset1");
    check_eq("reset_sig_const", int'(siguiente), 0);

    // Increment sequence, including misaligned PCs
    step(1'b0, 1'b1, 0, "inc0");
    check_eq("inc0_const", int'(siguiente), 4);
    step(1'b0, 1'b1, 3, "inc3");
    check_eq("inc3_const", int'(siguiente), 7);
    step(1'b0, 1'b1, 5, "inc5");
    check_eq("inc5_const", int'(siguiente), 9);

    // Reset mid-operation, then recover
    step(1'b1, 1'b1, 5, "midrst");
    check_eq("midrst_valid_const", int'(valid), 0);
    step(1'b0, 1'b1, 0, "postrst");
    check_eq("postrst_const", int'(siguiente), 4);

    // Stall holds outputs while PC changes
    step(1'b0, 1'b1, 3, "prestall");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 100, "stall");
      check_eq("stall_const", int'(siguiente), 7);
    end
    step(1'b0, 1'b1, 100, "unstall");
    check_eq("unstall_const", int'(siguiente), 104);

    // Wrap boundary
    step(1'b0, 1'b1, 1020, "wrap1020");
    check_eq("wrap1020_const", int'(wrap), 1);
    step(1'b0, 1'b1, 1019, "wrap1019");
    check_eq("wrap1019_const", int'(siguiente), 1023);
    step(1'b0, 1'b1, 1023, "wrap1023");
    check_eq("wrap1023_const", int'(siguiente), 3);

    // Stall while wrap is set keeps wrap
    step(1'b0, 1'b0, 7, "wrapstall");

    // Reset beats enable
    step(1'b1, 1'b1, 1020, "prio");
    check_eq("prio_wrap_const", int'(wrap), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic e;
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 9) < 7);
      if ((i % 50) == 7)
        step(r, e, MODV - 1 - int'($urandom_range(0, 5)), "rand_edge");
      else
        step(r, e, int'($urandom_range(0, MODV - 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", check_cnt_s, bad_cnt_s);
    $finish;
  end

endmodule
